// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a single-port synchronous memory between an instruction-fetch
//   port (if_*) and a data port (dm_*). Data accesses win ties unless fetch
//   has been passed over STARVE_MAX consecutive times while requesting.
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   if_req/if_addr       : fetch request (level, held until if_ack) and address
//   if_rdata/if_ack      : registered fetch data, one-cycle completion pulse
//   if_stall             : if_req & ~if_ack
//   dm_req/dm_we/dm_addr/dm_wdata : data request, write flag, address, store data
//   dm_rdata/dm_ack      : registered load data, one-cycle completion pulse
//   dm_stall             : dm_req & ~dm_ack
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory-side access port
//
// Timing: the grant edge starts access cycle 1 (mem_en high, lat_cnt = 0).
// The ack pulses in the cycle where lat_cnt == MEM_LAT, which is when the
// memory presents mem_rdata; the rdata register captures it at the end of
// that cycle. The FSM then spends one cycle in IDLE before the next grant.
// MEM_LAT must lie in 1..7 (lat_cnt is 3 bits wide).
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [2:0]    LAT    = 3'(MEM_LAT);
  localparam logic [2:0]    LAT_M1 = 3'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_DM = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_lat_cnt;
  logic [SW-1:0]     r_starve_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;

  logic w_grant_dm;
  logic w_grant_if;

  // Data port wins ties unless fetch has hit the starvation limit.
  assign w_grant_dm = dm_req & ~(if_req & (r_starve_cnt == S_MAX));
  assign w_grant_if = if_req & ~w_grant_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses by default.
      r_mem_en <= 1'b0;
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_state     <= ACC_DM;
            r_lat_cnt   <= '0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            // Count only grants that actually bypassed a waiting fetch.
            if (if_req) begin
              if (r_starve_cnt != S_MAX) begin
                r_starve_cnt <= r_starve_cnt + S_ONE;
              end
            end else begin
              r_starve_cnt <= '0;
            end
          end else if (w_grant_if) begin
            r_state      <= ACC_IF;
            r_lat_cnt    <= '0;
            r_mem_en     <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_starve_cnt <= '0;
          end
        end
        ACC_IF, ACC_DM: begin
          if (r_lat_cnt == LAT) begin
            // Ack cycle: data is on mem_rdata now; capture and release.
            r_state <= IDLE;
            if (r_state == ACC_IF) begin
              r_if_rdata <= mem_rdata;
            end else if (!r_mem_we) begin
              r_dm_rdata <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
            // Raise the ack so it coincides with lat_cnt == MEM_LAT.
            if (r_lat_cnt == LAT_M1) begin
              if (r_state == ACC_IF) begin
                r_if_ack <= 1'b1;
              end else begin
                r_dm_ack <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ack    = r_if_ack;
  assign dm_ack    = r_dm_ack;
  assign if_stall  = if_req & ~r_if_ack;
  assign dm_stall  = dm_req & ~r_dm_ack;

endmodule
